// File: rtl/spi_slv_pkg.sv
// Shared types for the SPI slave: FSM states, command codes and frame extension.
// SPI_SLV_PARITY_EN adds one parity bit after the command+payload bits of every frame.
package spi_slv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

`ifdef SPI_SLV_PARITY_EN
  localparam int unsigned ParityBits = 1;
`else
  localparam int unsigned ParityBits = 0;
`endif

endpackage

// File: rtl/spi_slv_piso.sv
// MSB-first parallel-in/serial-out shifter for SPI read data.
// load_i captures data_i; the MSB appears on sdo_o the following cycle and one bit
// is shifted out per clk for DATA_W cycles. sdo_o is 0 whenever nothing is pending.
module spi_slv_piso #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              sdo_o,
  output logic              done_o
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Next-state: abort wins over load, load wins over shifting.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (load_i) begin
      sh_d  = data_i;
      cnt_d = CntW'(DATA_W);
    end else if (cnt_q != '0) begin
      sh_d  = {sh_q[DATA_W-2:0], 1'b0};
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Shift register and remaining-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign sdo_o  = (cnt_q != '0) & sh_q[DATA_W-1];
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave running on the system clock: frames of {cmd[1:0], payload} arrive MSB first
// on MOSI while SS_n is low; a read-address frame arms the next read frame, which then
// returns tx_data on MISO. Build option SPI_SLV_PARITY_EN appends a parity bit per frame.
module spi_slave_gen
  import spi_slv_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MOSI,
  input  logic              SS_n,
  output logic              MISO,
  output logic              rx_valid,
  output logic [DATA_W+1:0] rx_data,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_err
);

  localparam int unsigned FRAME_W  = DATA_W + 2;
  localparam int unsigned FrameLen = FRAME_W + ParityBits;
  localparam int unsigned CntW     = $clog2(FrameLen + 1);
  localparam logic [CntW-1:0] CntData = CntW'(FRAME_W);
  localparam logic [CntW-1:0] CntLast = CntW'(FrameLen - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FrameLen);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [FRAME_W-1:0] sh_q, sh_d, shifted, word;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rd_armed_q, rd_armed_d;
  logic               rd_go_q, rd_go_d;
  logic               frame_ok;
  logic               piso_load, piso_clr, piso_done;

  assign shifted = {sh_q[FRAME_W-2:0], MOSI};

`ifdef SPI_SLV_PARITY_EN
  logic rx_err_q, rx_err_d;
  // Parity bit flags an odd count of ones, so the XOR over frame+parity must be 0.
  assign word     = sh_q;
  assign frame_ok = ~(^{sh_q, MOSI});
  assign rx_err   = rx_err_q;
`else
  assign word     = shifted;
  assign frame_ok = 1'b1;
  assign rx_err   = 1'b0;
`endif

  // Next-state: FSM, receive shifting, frame completion and read-data capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rd_armed_d = rd_armed_q;
    rd_go_d    = rd_go_q;
    piso_load  = 1'b0;
    piso_clr   = 1'b0;
`ifdef SPI_SLV_PARITY_EN
    rx_err_d   = 1'b0;
`endif
    if (SS_n) begin
      state_d  = IDLE;
      cnt_d    = '0;
      rd_go_d  = 1'b0;
      piso_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE:    state_d = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)          state_d = WRITE;
          else if (rd_armed_q) state_d = READ_DATA;
          else                state_d = READ_ADD;
        end
        default: state_d = state_q;
      endcase

      // Counter saturates at the frame length so extra clocks cannot re-trigger.
      if (state_q != IDLE && cnt_q != CntFull) begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q < CntData) sh_d = shifted;
        if (cnt_q == CntLast) begin
          if (frame_ok) begin
            rx_valid_d = 1'b1;
            rx_data_d  = word;
            rd_armed_d = (state_q == READ_ADD);
            rd_go_d    = (state_q == READ_DATA);
          end else begin
`ifdef SPI_SLV_PARITY_EN
            rx_err_d = 1'b1;
`endif
          end
        end
      end

      // Read data is taken once, on the first tx_valid after the read frame completes.
      if (state_q == READ_DATA && rd_go_q && tx_valid && piso_done) begin
        piso_load = 1'b1;
        rd_go_d   = 1'b0;
      end
    end
  end

  // State and receive-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rd_armed_q <= 1'b0;
      rd_go_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_armed_q <= rd_armed_d;
      rd_go_q    <= rd_go_d;
    end
  end

`ifdef SPI_SLV_PARITY_EN
  // Parity error pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_err_q <= 1'b0;
    else        rx_err_q <= rx_err_d;
  end
`endif

  spi_slv_piso #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (piso_load),
    .clr_i  (piso_clr),
    .data_i (tx_data),
    .sdo_o  (MISO),
    .done_o (piso_done)
  );

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Self-checking bench for spi_slave_gen (DATA_W=8): directed frames followed by random
// frames, each checked cycle by cycle against a frame-level reference model.
module tb_spi_slave_gen;
  import spi_slv_pkg::*;

  localparam int DW = 8;
  localparam int FW = DW + 2;
`ifdef SPI_SLV_PARITY_EN
  localparam int FL = FW + 1;
`else
  localparam int FL = FW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          MOSI = 1'b0;
  logic          SS_n = 1'b1;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          MISO, rx_valid, rx_err;
  logic [FW-1:0] rx_data;

  int tests = 0;
  int fails = 0;

  // Reference model state carried across frames.
  logic          m_armed = 1'b0;
  logic [FW-1:0] m_rx_data = '0;

  spi_slave_gen #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MOSI     (MOSI),
    .SS_n     (SS_n),
    .MISO     (MISO),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .rx_err   (rx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Builds the on-wire bit vector; bad=1 corrupts the parity bit when parity is enabled.
  function automatic logic [FL-1:0] mk(input logic [FW-1:0] f, input logic bad);
    logic [FL-1:0] v;
`ifdef SPI_SLV_PARITY_EN
    v = {f, (^f) ^ bad};
`else
    v = f ^ {FW{bad & 1'b0}};
`endif
    return v;
  endfunction

  // Runs one frame: SS_n low for nclk clock edges (nclk-1 bits sampled), then SS_n high.
  // rst_at >= 0 asserts reset between edges at that sample index and abandons the frame.
  task automatic do_frame(input logic [FL-1:0] bits, input int nclk, input logic txv,
                          input logic [DW-1:0] txd, input int rst_at, input string tag);
    state_e exp_st;
    logic   complete, ok, exp_v, exp_e, exp_m;
    int     j;
    exp_st   = !bits[FL-1] ? WRITE : (m_armed ? READ_DATA : READ_ADD);
    complete = (nclk - 1) >= FL;
    ok       = ~(^bits) | (FL == FW);
    SS_n     = 1'b0;
    MOSI     = 1'b0;
    tx_valid = txv;
    tx_data  = txd;
    for (int k = 0; k < nclk; k++) begin
      @(negedge clk);
      exp_v = complete && ok && (k == FL);
      exp_e = complete && !ok && (k == FL);
      j     = k - FL - 1;
      exp_m = (complete && ok && exp_st == READ_DATA && txv && j >= 0 && j < DW) ?
              txd[DW-1-j] : 1'b0;
      if (exp_v) m_rx_data = bits[FL-1 -: FW];
      check({tag, " rx_valid"}, 32'(rx_valid), 32'(exp_v));
      check({tag, " rx_err"}, 32'(rx_err), 32'(exp_e));
      check({tag, " MISO"}, 32'(MISO), 32'(exp_m));
      check({tag, " rx_data"}, 32'(rx_data), 32'(m_rx_data));
      if (k == 0) check({tag, " state chk"}, 32'(dut.state_q), 32'(CHK_CMD));
      if (k == 1) check({tag, " state cmd"}, 32'(dut.state_q), 32'(exp_st));
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        m_armed   = 1'b0;
        m_rx_data = '0;
        check({tag, " rst MISO"}, 32'(MISO), 32'd0);
        check({tag, " rst state"}, 32'(dut.state_q), 32'(IDLE));
        check({tag, " rst armed"}, 32'(dut.rd_armed_q), 32'd0);
        check({tag, " rst rx_data"}, 32'(rx_data), 32'd0);
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      MOSI = (k < FL) ? bits[FL-1-k] : 1'($urandom);
      if (k == nclk - 1) SS_n = 1'b1;
    end
    if (complete && ok) m_armed = (exp_st == READ_ADD);
    @(negedge clk);
    tx_valid = 1'b0;
    check({tag, " end state"}, 32'(dut.state_q), 32'(IDLE));
    check({tag, " end MISO"}, 32'(MISO), 32'd0);
    check({tag, " end rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, " end armed"}, 32'(dut.rd_armed_q), 32'(m_armed));
  endtask

  initial begin
    logic [FW-1:0] f;
    int            n;
    repeat (3) @(negedge clk);
    check("reset MISO", 32'(MISO), 32'd0);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset rx_err", 32'(rx_err), 32'd0);
    check("reset state", 32'(dut.state_q), 32'(IDLE));
    check("reset armed", 32'(dut.rd_armed_q), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_frame(mk(10'h0A5, 1'b0), FL + 2, 1'b1, 8'h99, -1, "write");
    do_frame(mk(10'h23C, 1'b0), FL + 2, 1'b0, 8'h00, -1, "rd_addr");
    do_frame(mk(10'h0FF, 1'b0), 6, 1'b0, 8'h00, -1, "abort");
    do_frame(mk(10'h35A, 1'b0), FL + DW + 3, 1'b1, 8'hC3, -1, "rd_data");
    do_frame(mk(10'h0A5, 1'b0), 15, 1'b0, 8'h00, -1, "overrun");
    do_frame(mk(10'h2A1, 1'b0), FL + 2, 1'b0, 8'h00, -1, "rd_addr2");
    do_frame(mk(10'h300, 1'b0), FL + DW + 3, 1'b1, 8'hB6, FL + 1 + 6, "rst_mid");
    do_frame(mk(10'h05C, 1'b0), FL + 2, 1'b0, 8'h00, -1, "post_rst");
`ifdef SPI_SLV_PARITY_EN
    do_frame(mk(10'h0A5, 1'b1), FL + 2, 1'b0, 8'h00, -1, "par_bad");
    do_frame(mk(10'h0A5, 1'b0), FL + 2, 1'b0, 8'h00, -1, "par_good");
`endif

    repeat (40) begin
      f = FW'($urandom);
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FL) : $urandom_range(FL + 1, FL + DW + 4);
      do_frame(mk(f, 1'($urandom_range(0, 3) == 0)), n, 1'($urandom_range(0, 3) != 0),
               DW'($urandom), -1, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
